// File: rtl/if_stage_if.sv
// Word-fetch bus between the instruction-fetch stage and the memory controller.
interface if_stage_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, redirect handling and an optional
// direct-mapped instruction cache (enabled by defining ICACHE_EN).
module if_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned ICACHE_LINES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_id_stall,
   input  logic        jump_or_not,
   input  logic [31:0] jump_addr,
   if_stage_if.master  mem,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_stall
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_e;

   if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
      $error("ICACHE_LINES must be a power of two of at least 2");
   end

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_stall_q, if_stall_d;
   logic [31:0] buf_q, buf_d;
   logic        ack_pend_q, ack_pend_d;
   logic [31:0] ack_data_q, ack_data_d;

   logic        ack_c;
   logic [31:0] ack_word_c;
   logic        hit_c;
   logic [31:0] line_c;

   // An acknowledge seen while frozen is parked and replayed once rdy returns.
   assign ack_c      = rdy && mem_req_q && (mem.mem_ack || ack_pend_q);
   assign ack_word_c = ack_pend_q ? ack_data_q : mem.mem_data;

`ifdef ICACHE_EN
   localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   logic [ICACHE_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]        tag_mem  [ICACHE_LINES];
   logic [31:0]             data_mem [ICACHE_LINES];
   logic [IDX_W-1:0]        rd_idx, wr_idx;

   assign rd_idx = pc_q[IDX_W+1:2];
   assign wr_idx = mem_addr_q[IDX_W+1:2];
   assign hit_c  = valid_q[rd_idx] && (tag_mem[rd_idx] == pc_q[31:IDX_W+2]);
   assign line_c = data_mem[rd_idx];

   // Every completed fetch fills its line, including discarded ones.
   always_comb begin
      valid_d = valid_q;
      if (ack_c) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) valid_q <= '0;
      else      valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (ack_c) begin
         tag_mem[wr_idx]  <= mem_addr_q[31:IDX_W+2];
         data_mem[wr_idx] <= ack_word_c;
      end
   end
`else
   assign hit_c  = 1'b0;
   assign line_c = 32'h0000_0000;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if_stall_d = if_stall_q;
      buf_d      = buf_q;
      ack_pend_d = ack_pend_q;
      ack_data_d = ack_data_q;

      if (!rdy) begin
         if (mem_req_q && mem.mem_ack && !ack_pend_q) begin
            ack_pend_d = 1'b1;
            ack_data_d = mem.mem_data;
         end
      end else begin
         ack_pend_d = 1'b0;
         if (ack_c) mem_req_d = 1'b0;

         if (jump_or_not) begin
            pc_d       = jump_addr & 32'hFFFF_FFFC;
            if_stall_d = 1'b1;
            case (state_q)
               S_FETCH, S_DRAIN: state_d = ack_c ? S_IDLE : S_DRAIN;
               default:          state_d = S_IDLE;
            endcase
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (!if_id_stall) begin
                     if (hit_c) begin
                        if_inst_d  = line_c;
                        if_pc_d    = pc_q;
                        if_stall_d = 1'b0;
                        pc_d       = pc_q + 32'd4;
                     end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        if_stall_d = 1'b1;
                        state_d    = S_FETCH;
                     end
                  end
               end
               S_FETCH: begin
                  if (ack_c) begin
                     if (if_id_stall) begin
                        buf_d   = ack_word_c;
                        state_d = S_HOLD;
                     end else begin
                        if_inst_d  = ack_word_c;
                        if_pc_d    = pc_q;
                        if_stall_d = 1'b0;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_IDLE;
                     end
                  end
               end
               S_HOLD: begin
                  if (!if_id_stall) begin
                     if_inst_d  = buf_q;
                     if_pc_d    = pc_q;
                     if_stall_d = 1'b0;
                     pc_d       = pc_q + 32'd4;
                     state_d    = S_IDLE;
                  end
               end
               S_DRAIN: begin
                  if (ack_c) state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= 32'h0000_0000;
         if_pc_q    <= 32'h0000_0000;
         if_inst_q  <= 32'h0000_0000;
         if_stall_q <= 1'b1;
         buf_q      <= 32'h0000_0000;
         ack_pend_q <= 1'b0;
         ack_data_q <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
         if_stall_q <= if_stall_d;
         buf_q      <= buf_d;
         ack_pend_q <= ack_pend_d;
         ack_data_q <= ack_data_d;
      end
   end

   assign mem.mem_req  = mem_req_q;
   assign mem.mem_addr = mem_addr_q;
   assign if_pc        = if_pc_q;
   assign if_inst      = if_inst_q;
   assign if_stall     = if_stall_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: memory responder plus a program-order model of the
// instruction stream (expected next PC and memory contents per address).
module tb_if_stage;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        if_id_stall;
   logic        jump_or_not;
   logic [31:0] jump_addr;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_stall;

   if_stage_if mem ();

   if_stage #(.RESET_PC(RESET_PC), .ICACHE_LINES(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .if_id_stall (if_id_stall),
      .jump_or_not (jump_or_not),
      .jump_addr   (jump_addr),
      .mem         (mem),
      .if_pc       (if_pc),
      .if_inst     (if_inst),
      .if_stall    (if_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          delivered = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic        prev_stall = 1'b1;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_inst = '0;
   logic [31:0] req_log[$];
   logic        busy = 1'b0;
   logic        acked = 1'b0;
   int          cnt = 0;
   int          lat = 2;
   logic        auto_mem = 1'b1;
   logic [31:0] req_addr = '0;
   logic [31:0] bad_pc = 32'hFFFF_FFFF;
   logic        saw_bad = 1'b0;

   // Memory image: low addresses hold NOPs, the rest an address hash.
   function automatic logic [31:0] word(input logic [31:0] a);
      if (a < 32'h10) return 32'h0000_0013;
      return ((a ^ 32'h5A5A_1234) * 32'h0001_0003) + 32'h0000_0077;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: account the edge in the model, then sample and respond.
   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst && rdy) begin
         if (jump_or_not) exp_pc = jump_addr & 32'hFFFF_FFFC;
         else if (!prev_stall && !if_id_stall) begin
            chk("deliver_pc", prev_pc, exp_pc);
            chk("deliver_inst", prev_inst, word(prev_pc));
            delivered++;
            exp_pc = exp_pc + 32'd4;
         end
      end
      #1;
      prev_stall = if_stall;
      prev_pc    = if_pc;
      prev_inst  = if_inst;
      if (!if_stall && (if_pc == bad_pc)) saw_bad = 1'b1;
      if (auto_mem && mem.mem_ack) mem.mem_ack = 1'b0;
      if (!mem.mem_req || !rst) begin
         busy  = 1'b0;
         acked = 1'b0;
      end else if (!acked) begin
         if (!busy) begin
            busy     = 1'b1;
            cnt      = 0;
            req_addr = mem.mem_addr;
            req_log.push_back(mem.mem_addr);
            chk("req_addr", mem.mem_addr, exp_pc);
         end else begin
            chk("req_stable", mem.mem_addr, req_addr);
         end
         if (auto_mem) begin
            if (cnt >= lat) begin
               mem.mem_ack  = 1'b1;
               mem.mem_data = word(req_addr);
               acked        = 1'b1;
            end else begin
               cnt++;
            end
         end
      end
   endtask

   task automatic wait_present(input string tag, input logic [31:0] pc, input int maxc);
      logic found;
      found = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (!if_stall && (if_pc == pc)) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_new_req(input string tag, input int maxc);
      int   n;
      logic found;
      n     = req_log.size();
      found = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         tick();
         if (req_log.size() > n) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic model_reset();
      exp_pc     = RESET_PC;
      prev_stall = 1'b1;
      busy       = 1'b0;
      acked      = 1'b0;
   endtask

   initial begin
      int n0;
      int t0;
      int nz;
      int d0;
      rst = 1'b0; rdy = 1'b1; if_id_stall = 1'b0; jump_or_not = 1'b0; jump_addr = '0;
      mem.mem_ack = 1'b0; mem.mem_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(mem.mem_req), 32'd0);
      chk("rst_mem_addr", mem.mem_addr, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      chk("rst_if_stall", 32'(if_stall), 32'd1);
      rst = 1'b1;

      // Sequential fetch from reset with two-cycle memory latency.
      lat = 2; nz = 0;
      for (int i = 0; i < 60 && delivered < 3; i++) begin
         if (!if_stall) nz++;
         tick();
      end
      chk("seq_delivered", 32'(delivered), 32'd3);
      chk("seq_valid_cycles", 32'(nz), 32'd3);
      chk("seq_addr0", req_log[0], 32'h0);
      chk("seq_addr1", req_log[1], 32'h4);
      chk("seq_addr2", req_log[2], 32'h8);

      // Loop 0..8 twice.
      for (int pass = 0; pass < 2; pass++) begin
         jump_or_not = 1'b1; jump_addr = 32'h0; tick(); jump_or_not = 1'b0;
         n0 = req_log.size();
         wait_present("loop_see0", 32'h0, 60);
         t0 = cyc;
         tick();
         wait_present("loop_see8", 32'h8, 60);
`ifdef ICACHE_EN
         chk("loop_no_req", 32'(req_log.size() - n0), 32'd0);
         chk("loop_rate", 32'(cyc - t0), 32'd2);
`else
         chk("loop_reqs", 32'(req_log.size() - n0), 32'd3);
`endif
      end

      // Downstream stall across the acknowledge.
      lat = 2;
      jump_or_not = 1'b1; jump_addr = 32'h100; tick(); jump_or_not = 1'b0;
      wait_new_req("hold_req", 40);
      chk("hold_req_addr", req_log[$], 32'h100);
      if_id_stall = 1'b1;
      repeat (3) tick();
      chk("hold_bubble", 32'(if_stall), 32'd1);
      chk("hold_req_drop", 32'(mem.mem_req), 32'd0);
      if_id_stall = 1'b0;
      tick();
      chk("hold_valid", 32'(if_stall), 32'd0);
      chk("hold_pc", if_pc, 32'h100);
      chk("hold_inst", if_inst, word(32'h100));

      // Redirect during an outstanding fetch.
      lat = 4; bad_pc = 32'h104; saw_bad = 1'b0;
      wait_new_req("drain_req", 40);
      chk("drain_req_addr", req_log[$], 32'h104);
      jump_or_not = 1'b1; jump_addr = 32'h0000_1003; tick(); jump_or_not = 1'b0;
      chk("drain_req_held", 32'(mem.mem_req), 32'd1);
      chk("drain_bubble", 32'(if_stall), 32'd1);
      wait_new_req("drain_next", 40);
      chk("drain_next_addr", req_log[$], 32'h1000);
      wait_present("drain_see", 32'h1000, 40);
      chk("drain_discarded", 32'(saw_bad), 32'd0);

      // Acknowledge arriving while frozen.
      lat = 1;
      wait_new_req("frz_req", 40);
      rdy = 1'b0;
      repeat (3) begin
         tick();
         chk("frz_req_held", 32'(mem.mem_req), 32'd1);
         chk("frz_bubble", 32'(if_stall), 32'd1);
      end
      rdy = 1'b1;
      tick();
      chk("frz_valid", 32'(if_stall), 32'd0);
      chk("frz_pc", if_pc, 32'h1004);
      chk("frz_inst", if_inst, word(32'h1004));

      // Reset during a fetch, then a stray acknowledge.
      lat = 20;
      wait_new_req("rfetch_req", 40);
      auto_mem = 1'b0;
      rst = 1'b0;
      #1;
      chk("rfetch_req_off", 32'(mem.mem_req), 32'd0);
      chk("rfetch_addr", mem.mem_addr, 32'd0);
      chk("rfetch_stall", 32'(if_stall), 32'd1);
      model_reset();
      tick(); tick();
      rst = 1'b1;
      mem.mem_ack = 1'b1; mem.mem_data = 32'hDEAD_BEEF;
      tick();
      mem.mem_ack = 1'b0;
      chk("rfetch_first", req_log[$], RESET_PC);
      auto_mem = 1'b1; lat = 1;
      wait_present("rfetch_see", RESET_PC, 40);
      chk("rfetch_inst", if_inst, word(RESET_PC));

      // PC wrap at the top of the address space, starting from a cold cache.
      rst = 1'b0;
      #1;
      model_reset();
      tick();
      rst = 1'b1;
      jump_or_not = 1'b1; jump_addr = 32'hFFFF_FFFE; tick(); jump_or_not = 1'b0;
      wait_new_req("wrap_req", 40);
      chk("wrap_req_addr", req_log[$], 32'hFFFF_FFFC);
      wait_present("wrap_see", 32'hFFFF_FFFC, 40);
      wait_new_req("wrap_next", 40);
      chk("wrap_next_addr", req_log[$], 32'h0);
      wait_present("wrap_see0", 32'h0, 40);

      // Randomized traffic against the program-order model.
      d0 = delivered;
      for (int i = 0; i < 1500; i++) begin
         lat         = int'($urandom_range(0, 3));
         if_id_stall = ($urandom_range(0, 3) == 0);
         rdy         = ($urandom_range(0, 7) != 0);
         jump_or_not = ($urandom_range(0, 19) == 0);
         jump_addr   = 32'($urandom_range(0, 1023));
         tick();
      end
      rdy = 1'b1; if_id_stall = 1'b0; jump_or_not = 1'b0;
      repeat (20) tick();
      chk("rand_progress", 32'(delivered - d0 > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
